route_compute_unit: RTL and testbench
=====================================

// Module: route_compute_unit
// PURPOSE
//  Per-input-port XY route computation for the mesh NoC router. Inspects the flit
//  at the head of the input buffer. On a head flit it computes the output port and
//  writes it into that port's next-hop register via nhr_address_o/nhr_write_o.
//  Holds the route (wormhole) until the tail flit leaves the buffer. One instance
//  per input port, sitting between the input buffer and the next-hop register.
// PARAMETERS
//  FLIT_WIDTH  32  flit width; [FW-1:FW-2]=type (01 head, 00 body, 10 tail, 11 head+tail)
//  COORD_W     2   coordinate width; dest_x=[COORD_W-1:0], dest_y=[2*COORD_W-1:COORD_W]
//  MESH_X      4   mesh columns; valid dest_x range 0..MESH_X-1
//  MESH_Y      4   mesh rows; valid dest_y range 0..MESH_Y-1
//  CUR_X       0   this router's x coordinate
//  CUR_Y       0   this router's y coordinate
// PORTS
//  clk            in   1           clock
//  reset          in   1           synchronous, active-high reset
//  ib_empty_i     in   1           input buffer empty; ib_flit_i invalid when 1
//  ib_flit_i      in   FLIT_WIDTH  flit at head of input buffer
//  ib_pop_i       in   1           head flit dequeued this cycle (switch traversal)
//  nhr_address_o  out  3           computed output port code
//  nhr_write_o    out  1           one-cycle write strobe to next-hop register
//  route_busy_o   out  1           packet in flight; route held
//  dest_err_o     out  1           sticky: out-of-range destination seen
//  proto_err_o    out  1           sticky: body/tail in IDLE, or pop while empty
//  pkt_count_o    out  16          packets routed, saturating
// BEHAVIOUR
//  Port codes: N=000, E=001, S=010, IDLE=011 (no route), W=100, L=101.
//  Reset: state IDLE, nhr_address_o=IDLE(011), nhr_write_o=0, route_busy_o=0,
//   dest_err_o=0, proto_err_o=0, pkt_count_o=0. Reset wins over all other inputs.
//  Reset mid-packet abandons the route; the next head is routed fresh.
//  FSM IDLE -> ACTIVE:
//   In IDLE, when !ib_empty_i and type is head (01 or 11) at cycle T:
//   - at T+1: nhr_address_o=route, nhr_write_o=1 for exactly one cycle.
//   - state ACTIVE, route_busy_o=1, pkt_count_o+1 (saturate at 16'hFFFF).
//  XY rule, evaluated in this order:
//   - dx>CUR_X -> E; dx<CUR_X -> W;
//   - else dy>CUR_Y -> N; dy<CUR_Y -> S;
//   - else L.
//  Out-of-range destination (dx>=MESH_X or dy>=MESH_Y): route=L, dest_err_o<=1.
//   The packet drains to the local sink.
//  ACTIVE: nhr_address_o is held and nhr_write_o=0. Body flits and empty cycles
//   are ignored.
//  ACTIVE -> IDLE: ib_pop_i with type tail (10) or head+tail (11).
//   - nhr_address_o<=IDLE the next cycle.
//   - The next head is considered no earlier than the cycle after the pop.
//   - A single-flit packet (11) popped in the cycle after its write returns to IDLE.
//  Head flit seen in ACTIVE: treated as body (no re-route); not an error.
//  IDLE with front flit body/tail: proto_err_o<=1, no write, stay IDLE.
//  ib_pop_i while ib_empty_i: ignored, proto_err_o<=1.
//  nhr_write_o is never asserted on two consecutive cycles.
// STRUCTURE
//  noc_pkg:
//   - port_code_e enum (N,E,S,IDLE,W,L)
//   - flit_type_e enum
//   - FLIT_TYPE_HI/LO constants
//   - function xy_route(dx,dy,cx,cy)
//  Sub-module xy_route_logic: combinational port decision plus range check.
//  The FSM, counter and error flags live in route_compute_unit.
// TESTING
//  CUR=(1,1), head dest (3,1) at T -> T+1 nhr_address_o=001, nhr_write_o=1; T+2 write=0, busy=1.
//  Heads to (0,2),(1,0),(1,2),(1,1) -> W=100, S=010, N=000, L=101 respectively.
//  Head(2,1), 3 bodies, tail popped at T -> T+1 nhr_address_o=011, busy=0, pkt_count_o=1.
//  Head dest (5,0) on 4x4 mesh -> route 101, dest_err_o=1 stays set until reset.
//  Body flit in IDLE -> no write, proto_err_o=1.
//  Reset asserted mid-packet -> next cycle all outputs at reset values.
//  Head+tail (11) back-to-back packets -> one write per packet; writes >=2 cycles apart.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and helpers for the mesh NoC router: output port codes,
// flit type encoding and the dimension-ordered (XY) routing decision.
package noc_pkg;

   // Output port codes written into the next-hop register.
   typedef enum logic [2:0] {
      PORT_N    = 3'b000,
      PORT_E    = 3'b001,
      PORT_S    = 3'b010,
      PORT_IDLE = 3'b011,
      PORT_W    = 3'b100,
      PORT_L    = 3'b101
   } port_code_e;

   // Flit type carried in the two most significant flit bits.
   typedef enum logic [1:0] {
      FLIT_BODY      = 2'b00,
      FLIT_HEAD      = 2'b01,
      FLIT_TAIL      = 2'b10,
      FLIT_HEAD_TAIL = 2'b11
   } flit_type_e;

   // Distance below FLIT_WIDTH of the type field's MSB and LSB.
   localparam int FLIT_TYPE_HI = 1;
   localparam int FLIT_TYPE_LO = 2;

   // X is resolved before Y; a packet already at its column and row is ejected locally.
   function automatic port_code_e xy_route(input int unsigned dx, input int unsigned dy,
                                           input int unsigned cx, input int unsigned cy);
      if (dx > cx)      return PORT_E;
      else if (dx < cx) return PORT_W;
      else if (dy > cy) return PORT_N;
      else if (dy < cy) return PORT_S;
      else              return PORT_L;
   endfunction

endpackage

// File: rtl/xy_route_logic.sv
// Combinational route decision for one destination: XY port choice, with
// unreachable destinations steered to the local sink and flagged.
module xy_route_logic
   import noc_pkg::*;
#(
   parameter int COORD_W = 2,
   parameter int MESH_X  = 4,
   parameter int MESH_Y  = 4,
   parameter int CUR_X   = 0,
   parameter int CUR_Y   = 0
) (
   input  logic [COORD_W-1:0] dest_x,
   input  logic [COORD_W-1:0] dest_y,
   output port_code_e         route,
   output logic               out_of_range
);

   localparam int unsigned CX = CUR_X;
   localparam int unsigned CY = CUR_Y;
   localparam int unsigned MX = MESH_X;
   localparam int unsigned MY = MESH_Y;

   logic [31:0] dx_wide;
   logic [31:0] dy_wide;

   assign dx_wide = 32'(dest_x);
   assign dy_wide = 32'(dest_y);

   // Out-of-mesh destinations drain to the local port instead of wandering off the edge.
   always_comb begin
      out_of_range = (dx_wide >= MX) || (dy_wide >= MY);
      route        = out_of_range ? PORT_L : xy_route(dx_wide, dy_wide, CX, CY);
   end

endmodule

// File: rtl/route_compute_unit.sv
// Per-input-port route computation: routes each head flit once, holds the
// route for the whole wormhole packet, and releases it when the tail leaves.
module route_compute_unit
   import noc_pkg::*;
#(
   parameter int FLIT_WIDTH = 32,
   parameter int COORD_W    = 2,
   parameter int MESH_X     = 4,
   parameter int MESH_Y     = 4,
   parameter int CUR_X      = 0,
   parameter int CUR_Y      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ib_empty_i,
   input  logic [FLIT_WIDTH-1:0] ib_flit_i,
   input  logic                  ib_pop_i,
   output logic [2:0]            nhr_address_o,
   output logic                  nhr_write_o,
   output logic                  route_busy_o,
   output logic                  dest_err_o,
   output logic                  proto_err_o,
   output logic [15:0]           pkt_count_o
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

   state_e       state_reg, state_next;
   port_code_e   addr_reg, addr_next;
   logic         write_reg, write_next;
   logic         dest_err_reg, dest_err_next;
   logic         proto_err_reg, proto_err_next;
   logic [15:0]  count_reg, count_next;

   flit_type_e   ftype;
   logic         is_head;
   logic         is_last;
   port_code_e   route;
   logic         out_of_range;
   logic         unused_payload;

   assign ftype   = flit_type_e'(ib_flit_i[FLIT_WIDTH-FLIT_TYPE_HI -: 2]);
   assign is_head = (ftype == FLIT_HEAD) || (ftype == FLIT_HEAD_TAIL);
   assign is_last = (ftype == FLIT_TAIL) || (ftype == FLIT_HEAD_TAIL);
   assign unused_payload = ^ib_flit_i[FLIT_WIDTH-FLIT_TYPE_LO-1:2*COORD_W];

   xy_route_logic #(
      .COORD_W (COORD_W),
      .MESH_X  (MESH_X),
      .MESH_Y  (MESH_Y),
      .CUR_X   (CUR_X),
      .CUR_Y   (CUR_Y)
   ) u_xy_route_logic (
      .dest_x       (ib_flit_i[COORD_W-1:0]),
      .dest_y       (ib_flit_i[2*COORD_W-1:COORD_W]),
      .route        (route),
      .out_of_range (out_of_range)
   );

   // State and output registers; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= PORT_IDLE;
         write_reg     <= 1'b0;
         dest_err_reg  <= 1'b0;
         proto_err_reg <= 1'b0;
         count_reg     <= 16'd0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         write_reg     <= write_next;
         dest_err_reg  <= dest_err_next;
         proto_err_reg <= proto_err_next;
         count_reg     <= count_next;
      end
   end

   // Next-state logic: route a head in IDLE, release on a popped tail in ACTIVE.
   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      write_next     = 1'b0;
      dest_err_next  = dest_err_reg;
      proto_err_next = proto_err_reg;
      count_next     = count_reg;

      if (ib_pop_i && ib_empty_i) begin
         proto_err_next = 1'b1;
      end

      unique case (state_reg)
         ST_IDLE: begin
            if (!ib_empty_i) begin
               if (is_head) begin
                  state_next = ST_ACTIVE;
                  addr_next  = route;
                  write_next = 1'b1;
                  if (out_of_range) begin
                     dest_err_next = 1'b1;
                  end
                  if (count_reg != 16'hFFFF) begin
                     count_next = count_reg + 16'd1;
                  end
               end else begin
                  // Body or tail with no open route means the upstream framing is broken.
                  proto_err_next = 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            // Heads seen here are treated as body flits; only a popped last flit ends the packet.
            if (ib_pop_i && !ib_empty_i && is_last) begin
               state_next = ST_IDLE;
               addr_next  = PORT_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            addr_next  = PORT_IDLE;
         end
      endcase
   end

   assign nhr_address_o = addr_reg;
   assign nhr_write_o   = write_reg;
   assign route_busy_o  = (state_reg == ST_ACTIVE);
   assign dest_err_o    = dest_err_reg;
   assign proto_err_o   = proto_err_reg;
   assign pkt_count_o   = count_reg;

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit at CUR=(1,1) on a 4x4 mesh with 3-bit coordinates
// so that out-of-mesh destinations are representable.
module tb_route_compute_unit;

   localparam int FW = 32;
   localparam int CW = 3;
   localparam int MX = 4;
   localparam int MY = 4;
   localparam int CX = 1;
   localparam int CY = 1;

   logic          clk;
   logic          reset;
   logic          ib_empty;
   logic [FW-1:0] ib_flit;
   logic          ib_pop;
   logic [2:0]    nhr_address;
   logic          nhr_write;
   logic          route_busy;
   logic          dest_err;
   logic          proto_err;
   logic [15:0]   pkt_count;

   int checks = 0;
   int errors = 0;

   route_compute_unit #(
      .FLIT_WIDTH (FW),
      .COORD_W    (CW),
      .MESH_X     (MX),
      .MESH_Y     (MY),
      .CUR_X      (CX),
      .CUR_Y      (CY)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ib_empty_i    (ib_empty),
      .ib_flit_i     (ib_flit),
      .ib_pop_i      (ib_pop),
      .nhr_address_o (nhr_address),
      .nhr_write_o   (nhr_write),
      .route_busy_o  (route_busy),
      .dest_err_o    (dest_err),
      .proto_err_o   (proto_err),
      .pkt_count_o   (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference routing from the XY rule written as plain arithmetic.
   function automatic int exp_route(input int dx, input int dy);
      if (dx >= MX || dy >= MY) return 5;
      if (dx > CX) return 1;
      if (dx < CX) return 4;
      if (dy > CY) return 0;
      if (dy < CY) return 2;
      return 5;
   endfunction

   // Applies one cycle of inputs; on return the DUT has sampled them.
   task automatic drive(input logic e, input int t, input int dx, input int dy,
                        input logic p, input logic r);
      logic [FW-1:0] f;
      logic [1:0]    tt;
      logic [2:0]    x3;
      logic [2:0]    y3;
      tt = 2'(t);
      x3 = 3'(dx);
      y3 = 3'(dy);
      f = $urandom;
      f[FW-1:FW-2] = tt;
      f[5:3] = y3;
      f[2:0] = x3;
      ib_empty = e;
      ib_flit  = f;
      ib_pop   = p;
      reset    = r;
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: expected outputs after the next edge, from the packet-level rules.
   bit     m_valid = 0;
   bit     m_in_pkt;
   int     m_addr, m_write, m_derr, m_perr, m_count;

   always @(negedge clk) begin
      int t, dx, dy;
      if (m_valid) begin
         chk("nhr_address", int'(nhr_address), m_addr);
         chk("nhr_write",   int'(nhr_write),   m_write);
         chk("route_busy",  int'(route_busy),  int'(m_in_pkt));
         chk("dest_err",    int'(dest_err),    m_derr);
         chk("proto_err",   int'(proto_err),   m_perr);
         chk("pkt_count",   int'(pkt_count),   m_count);
      end
      t  = int'(ib_flit[FW-1:FW-2]);
      dx = int'(ib_flit[2:0]);
      dy = int'(ib_flit[5:3]);
      if (reset) begin
         m_in_pkt = 0; m_addr = 3; m_write = 0; m_derr = 0; m_perr = 0; m_count = 0;
         m_valid = 1;
      end else if (m_valid) begin
         m_write = 0;
         if (ib_pop && ib_empty) m_perr = 1;
         if (!m_in_pkt) begin
            if (!ib_empty) begin
               if (t == 1 || t == 3) begin
                  m_in_pkt = 1;
                  m_addr   = exp_route(dx, dy);
                  m_write  = 1;
                  if (dx >= MX || dy >= MY) m_derr = 1;
                  if (m_count < 65535) m_count++;
                  $display("txn head dest=(%0d,%0d) expect port=%0d count=%0d", dx, dy, m_addr, m_count);
               end else begin
                  m_perr = 1;
               end
            end
         end else if (ib_pop && !ib_empty && (t == 2 || t == 3)) begin
            m_in_pkt = 0;
            m_addr   = 3;
         end
      end
   end

   initial begin
      reset = 1'b1; ib_empty = 1'b1; ib_flit = '0; ib_pop = 1'b0;
      drive(1, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 1);
      chk("reset_addr", int'(nhr_address), 3);
      chk("reset_write", int'(nhr_write), 0);
      chk("reset_busy", int'(route_busy), 0);
      chk("reset_count", int'(pkt_count), 0);

      // Head (2,1), three bodies, tail popped.
      drive(0, 1, 2, 1, 0, 0);
      chk("e_route", int'(nhr_address), 1);
      chk("e_write", int'(nhr_write), 1);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
      chk("body_no_write", int'(nhr_write), 0);
      chk("body_busy", int'(route_busy), 1);
      drive(0, 2, 0, 0, 1, 0);
      chk("tail_addr", int'(nhr_address), 3);
      chk("tail_busy", int'(route_busy), 0);
      chk("tail_count", int'(pkt_count), 1);

      // Head (3,1): write one cycle only.
      drive(0, 1, 3, 1, 0, 0);
      chk("e31_route", int'(nhr_address), 1);
      chk("e31_write", int'(nhr_write), 1);
      drive(1, 0, 0, 0, 0, 0);
      chk("e31_write_drop", int'(nhr_write), 0);
      chk("e31_busy", int'(route_busy), 1);
      drive(0, 2, 0, 0, 1, 0);

      // W, S, N, L directions.
      drive(0, 1, 0, 2, 0, 0); chk("w_route", int'(nhr_address), 4); drive(0, 2, 0, 0, 1, 0);
      drive(0, 1, 1, 0, 0, 0); chk("s_route", int'(nhr_address), 2); drive(0, 2, 0, 0, 1, 0);
      drive(0, 1, 1, 2, 0, 0); chk("n_route", int'(nhr_address), 0); drive(0, 2, 0, 0, 1, 0);
      drive(0, 1, 1, 1, 0, 0); chk("l_route", int'(nhr_address), 5); drive(0, 2, 0, 0, 1, 0);
      chk("count_after_6", int'(pkt_count), 6);

      // Out-of-range destination sinks locally and sets the sticky flag.
      drive(0, 1, 5, 0, 0, 0);
      chk("oor_route", int'(nhr_address), 5);
      chk("oor_flag", int'(dest_err), 1);
      drive(0, 2, 0, 0, 1, 0);
      drive(0, 1, 3, 3, 0, 0);
      drive(0, 2, 0, 0, 1, 0);
      chk("oor_sticky", int'(dest_err), 1);
      chk("no_proto_yet", int'(proto_err), 0);

      // Body flit in IDLE.
      drive(0, 0, 2, 2, 0, 0);
      chk("idle_body_write", int'(nhr_write), 0);
      chk("idle_body_proto", int'(proto_err), 1);

      // Reset mid-packet, then a fresh head.
      drive(0, 1, 3, 1, 0, 0);
      drive(0, 1, 3, 1, 0, 1);
      chk("midrst_addr", int'(nhr_address), 3);
      chk("midrst_busy", int'(route_busy), 0);
      chk("midrst_derr", int'(dest_err), 0);
      chk("midrst_perr", int'(proto_err), 0);
      chk("midrst_count", int'(pkt_count), 0);
      drive(0, 1, 1, 2, 0, 0);
      chk("fresh_route", int'(nhr_address), 0);
      chk("fresh_write", int'(nhr_write), 1);
      drive(0, 2, 0, 0, 1, 0);

      // Pop while empty.
      drive(1, 0, 0, 0, 1, 0);
      chk("empty_pop_proto", int'(proto_err), 1);
      drive(1, 0, 0, 0, 0, 1);

      // Back-to-back head+tail packets.
      drive(0, 3, 3, 1, 0, 0);
      chk("ht1_write", int'(nhr_write), 1);
      drive(0, 3, 3, 1, 1, 0);
      chk("ht1_gap", int'(nhr_write), 0);
      chk("ht1_released", int'(route_busy), 0);
      drive(0, 3, 0, 1, 0, 0);
      chk("ht2_write", int'(nhr_write), 1);
      chk("ht2_route", int'(nhr_address), 4);
      drive(0, 3, 0, 1, 1, 0);
      chk("ht_count", int'(pkt_count), 2);

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               ($urandom_range(0, 1) == 1), ($urandom_range(0, 49) == 0));
      end
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
